argmax_stream_top2: RTL and testbench



---
 rtl/argmax_stream_top2.sv | 179 +++++++++++++++++
 tb/tb_argmax_stream_top2.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/argmax_stream_top2.sv
`default_nettype none
// ============================================================================
// Module   : argmax_stream_top2
// Brief    : Streaming top-2 arg-select over NUM_CLASS logits, LANES per beat,
//            with margin and confidence flag on a valid/ready result port.
// Revision : 1.0
// ============================================================================
module argmax_stream_top2 #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CLASS  = 24,
    parameter int LANES      = 4,
    parameter int SIGNED     = 1,
    parameter int IDX_W      = (NUM_CLASS > 2) ? $clog2(NUM_CLASS) : 1
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        flush,
    input  logic [DATA_WIDTH-1:0]       thresh,
    input  logic [LANES*DATA_WIDTH-1:0] in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [IDX_W-1:0]            top1_idx,
    output logic [DATA_WIDTH-1:0]       top1_val,
    output logic [IDX_W-1:0]            top2_idx,
    output logic [DATA_WIDTH-1:0]       top2_val,
    output logic [DATA_WIDTH-1:0]       margin,
    output logic                        confident
);

    localparam int NBEATS = (NUM_CLASS + LANES - 1) / LANES;
    localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CNT_W-1:0] C_LAST_BEAT = CNT_W'(NBEATS - 1);

    typedef enum logic [0:0] {
        S_ACCUM = 1'b0,
        S_DONE  = 1'b1
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_beat;
    logic [DATA_WIDTH-1:0] r_t1_val, r_t2_val;
    logic [IDX_W-1:0]      r_t1_idx, r_t2_idx;
    logic                  r_t2_vld;

    logic                  r_in_ready, r_out_valid, r_confident;
    logic [IDX_W-1:0]      r_top1_idx, r_top2_idx;
    logic [DATA_WIDTH-1:0] r_top1_val, r_top2_val, r_margin;

    logic [DATA_WIDTH-1:0] w_t1_val, w_t2_val, w_lane;
    logic [IDX_W-1:0]      w_t1_idx, w_t2_idx, w_lane_idx;
    logic                  w_t1_vld, w_t2_vld;
    int                    w_cls;
    logic [DATA_WIDTH:0]   w_ext1, w_ext2, w_diff;
    logic [DATA_WIDTH-1:0] w_margin;
    logic                  w_conf;

    function automatic logic f_gt(input logic [DATA_WIDTH-1:0] a,
                                  input logic [DATA_WIDTH-1:0] b);
        if (SIGNED != 0) return $signed(a) > $signed(b);
        return a > b;
    endfunction

    // Lanes are visited in ascending class order and only a strictly greater
    // value displaces an entry, so ties always keep the lower class index.
    always_comb begin
        w_t1_val   = r_t1_val;
        w_t1_idx   = r_t1_idx;
        w_t2_val   = r_t2_val;
        w_t2_idx   = r_t2_idx;
        w_t1_vld   = (r_beat != '0);
        w_t2_vld   = (r_beat != '0) && r_t2_vld;
        w_lane     = '0;
        w_lane_idx = '0;
        w_cls      = 0;
        for (int k = 0; k < LANES; k++) begin
            w_cls      = int'(r_beat) * LANES + k;
            w_lane     = in_data[k*DATA_WIDTH +: DATA_WIDTH];
            w_lane_idx = IDX_W'(w_cls);
            if (w_cls < NUM_CLASS) begin
                if (!w_t1_vld || f_gt(w_lane, w_t1_val)) begin
                    w_t2_val = w_t1_val;
                    w_t2_idx = w_t1_idx;
                    w_t2_vld = w_t1_vld;
                    w_t1_val = w_lane;
                    w_t1_idx = w_lane_idx;
                    w_t1_vld = 1'b1;
                end else if (!w_t2_vld || f_gt(w_lane, w_t2_val)) begin
                    w_t2_val = w_lane;
                    w_t2_idx = w_lane_idx;
                    w_t2_vld = 1'b1;
                end
            end
        end
    end

    // One extra bit keeps the signed difference exact before truncation.
    always_comb begin
        w_ext1   = (SIGNED != 0) ? {w_t1_val[DATA_WIDTH-1], w_t1_val} : {1'b0, w_t1_val};
        w_ext2   = (SIGNED != 0) ? {w_t2_val[DATA_WIDTH-1], w_t2_val} : {1'b0, w_t2_val};
        w_diff   = w_ext1 - w_ext2;
        w_margin = w_diff[DATA_WIDTH-1:0];
        w_conf   = (w_margin >= thresh);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_ACCUM;
            r_beat      <= '0;
            r_t1_val    <= '0;
            r_t1_idx    <= '0;
            r_t2_val    <= '0;
            r_t2_idx    <= '0;
            r_t2_vld    <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_top1_idx  <= '0;
            r_top1_val  <= '0;
            r_top2_idx  <= '0;
            r_top2_val  <= '0;
            r_margin    <= '0;
            r_confident <= 1'b0;
        end else begin
            case (r_state)
                S_ACCUM: begin
                    if (flush) begin
                        r_beat <= '0;
                    end else if (in_valid) begin
                        r_t1_val <= w_t1_val;
                        r_t1_idx <= w_t1_idx;
                        r_t2_val <= w_t2_val;
                        r_t2_idx <= w_t2_idx;
                        r_t2_vld <= w_t2_vld;
                        if (r_beat == C_LAST_BEAT) begin
                            r_beat      <= '0;
                            r_state     <= S_DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_top1_idx  <= w_t1_idx;
                            r_top1_val  <= w_t1_val;
                            r_top2_idx  <= w_t2_idx;
                            r_top2_val  <= w_t2_val;
                            r_margin    <= w_margin;
                            r_confident <= w_conf;
                        end else begin
                            r_beat <= r_beat + CNT_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (flush || out_ready) begin
                        r_state     <= S_ACCUM;
                        r_beat      <= '0;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_ACCUM;
                    r_beat      <= '0;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign top1_idx  = r_top1_idx;
    assign top1_val  = r_top1_val;
    assign top2_idx  = r_top2_idx;
    assign top2_val  = r_top2_val;
    assign margin    = r_margin;
    assign confident = r_confident;

endmodule
`default_nettype wire

// File: tb/tb_argmax_stream_top2.sv
`default_nettype none
// ============================================================================
// Module   : tb_argmax_stream_top2
// Brief    : Bench for argmax_stream_top2: signed 24/4, unsigned 24/4, padded 10/4.
// Revision : 1.0
// ============================================================================
module tb_argmax_stream_top2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] thresh = '0;
    logic [63:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_valid_c = 1'b0;
    logic        out_ready = 1'b0;

    logic        a_in_ready, a_out_valid, a_conf;
    logic [4:0]  a_i1, a_i2;
    logic [15:0] a_v1, a_v2, a_m;
    logic        b_in_ready, b_out_valid, b_conf;
    logic [4:0]  b_i1, b_i2;
    logic [15:0] b_v1, b_v2, b_m;
    logic        c_in_ready, c_out_valid, c_conf;
    logic [3:0]  c_i1, c_i2;
    logic [15:0] c_v1, c_v2, c_m;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [15:0] fr [24];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    argmax_stream_top2 #(.DATA_WIDTH(16), .NUM_CLASS(24), .LANES(4), .SIGNED(1)) u_a (
        .clk(clk), .resetn(resetn), .flush(flush), .thresh(thresh),
        .in_data(in_data), .in_valid(in_valid), .in_ready(a_in_ready),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .top1_idx(a_i1), .top1_val(a_v1), .top2_idx(a_i2), .top2_val(a_v2),
        .margin(a_m), .confident(a_conf));

    argmax_stream_top2 #(.DATA_WIDTH(16), .NUM_CLASS(24), .LANES(4), .SIGNED(0)) u_b (
        .clk(clk), .resetn(resetn), .flush(flush), .thresh(thresh),
        .in_data(in_data), .in_valid(in_valid), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .top1_idx(b_i1), .top1_val(b_v1), .top2_idx(b_i2), .top2_val(b_v2),
        .margin(b_m), .confident(b_conf));

    argmax_stream_top2 #(.DATA_WIDTH(16), .NUM_CLASS(10), .LANES(4), .SIGNED(1)) u_c (
        .clk(clk), .resetn(resetn), .flush(flush), .thresh(thresh),
        .in_data(in_data), .in_valid(in_valid_c), .in_ready(c_in_ready),
        .out_valid(c_out_valid), .out_ready(out_ready),
        .top1_idx(c_i1), .top1_val(c_v1), .top2_idx(c_i2), .top2_val(c_v2),
        .margin(c_m), .confident(c_conf));

    function automatic logic [58:0] obs_a();
        return {a_i1, a_v1, a_i2, a_v2, a_m, a_conf};
    endfunction
    function automatic logic [58:0] obs_b();
        return {b_i1, b_v1, b_i2, b_v2, b_m, b_conf};
    endfunction
    function automatic logic [58:0] obs_c();
        return {1'b0, c_i1, c_v1, 1'b0, c_i2, c_v2, c_m, c_conf};
    endfunction

    // Reference: order key maps two's-complement onto unsigned order; first max wins.
    function automatic logic [15:0] key(input logic [15:0] v, input bit sgn);
        return sgn ? (v ^ 16'h8000) : v;
    endfunction

    function automatic logic [58:0] model(input int n, input bit sgn, input logic [15:0] thr);
        int i1, i2, d;
        logic [15:0] m;
        i1 = 0;
        for (int i = 1; i < n; i++) if (key(fr[i], sgn) > key(fr[i1], sgn)) i1 = i;
        i2 = (i1 == 0) ? 1 : 0;
        for (int i = 0; i < n; i++)
            if (i != i1 && key(fr[i], sgn) > key(fr[i2], sgn)) i2 = i;
        if (sgn) d = int'($signed(fr[i1])) - int'($signed(fr[i2]));
        else     d = int'(fr[i1]) - int'(fr[i2]);
        m = d[15:0];
        return {i1[4:0], fr[i1], i2[4:0], fr[i2], m, (m >= thr)};
    endfunction

    task automatic rand_frame();
        logic [15:0] pool [5];
        pool = '{16'h7FFF, 16'h8000, 16'h0000, 16'hFFFF, 16'h0001};
        for (int i = 0; i < 24; i++)
            fr[i] = ($urandom_range(99) < 30) ? pool[$urandom_range(4)] : 16'($urandom);
    endtask

    // Presents beats b0..b0+nb-1, honouring in_ready; random idle gaps.
    task automatic drive_beats(input int b0, input int nb, input bit use_c, input int gap_pct);
        int b = b0;
        int budget = 0;
        bit rdy, v;
        while (b < b0 + nb && budget < 1000) begin
            v = ($urandom_range(99) >= gap_pct);
            for (int k = 0; k < 4; k++) in_data[k*16 +: 16] = v ? fr[b*4+k] : 16'($urandom);
            in_valid   = v && !use_c;
            in_valid_c = v && use_c;
            rdy = use_c ? c_in_ready : a_in_ready;
            @(posedge clk); #1;
            if (v && rdy && !flush) b++;
            budget++;
        end
        in_valid = 1'b0;
        in_valid_c = 1'b0;
        if (budget >= 1000) begin
            checks++; errors++;
            $display("FAIL drive_timeout beat=%0d required=%0d", b, b0 + nb);
        end
    endtask

    task automatic accept();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({obs_a(), a_out_valid, a_in_ready} !== {59'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_a got=%h/%b/%b required=0/0/1", obs_a(), a_out_valid, a_in_ready);
        end
        checks++;
        if ({obs_c(), c_out_valid, c_in_ready} !== {59'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_c got=%h/%b/%b required=0/0/1", obs_c(), c_out_valid, c_in_ready);
        end
        resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_ramp();
        for (int i = 0; i < 24; i++) fr[i] = 16'(i * 10);
        thresh = 16'd5;
        drive_beats(0, 6, 1'b0, 0);
        checks++;
        if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ramp_latency got=%b/%b required=1/0", a_out_valid, a_in_ready);
        end
        checks++;
        if ({a_i1, a_v1, a_i2, a_m, a_conf} !== {5'd23, 16'd230, 5'd22, 16'd10, 1'b1}) begin
            errors++;
            $display("FAIL ramp_a got=%0d,%0d,%0d,%0d,%b required=23,230,22,10,1",
                     a_i1, a_v1, a_i2, a_m, a_conf);
        end
        checks++;
        if (obs_b() !== model(24, 1'b0, thresh)) begin
            errors++;
            $display("FAIL ramp_b got=%h required=%h", obs_b(), model(24, 1'b0, thresh));
        end
        accept();
    endtask

    task automatic test_ties();
        for (int i = 0; i < 24; i++) fr[i] = 16'hFF9C;
        fr[3] = 16'h7FFF;
        fr[17] = 16'h7FFF;
        thresh = 16'd1;
        drive_beats(0, 6, 1'b0, 20);
        checks++;
        if ({a_i1, a_i2, a_m, a_conf} !== {5'd3, 5'd17, 16'd0, 1'b0}) begin
            errors++;
            $display("FAIL ties_signed got=%0d,%0d,%0d,%b required=3,17,0,0", a_i1, a_i2, a_m, a_conf);
        end
        checks++;
        if (obs_b() !== model(24, 1'b0, thresh)) begin
            errors++;
            $display("FAIL ties_unsigned_b got=%h required=%h", obs_b(), model(24, 1'b0, thresh));
        end
        accept();
        for (int i = 0; i < 24; i++) fr[i] = 16'h0001;
        fr[5] = 16'hFFFF;
        drive_beats(0, 6, 1'b0, 0);
        checks++;
        if (b_i1 !== 5'd5 || obs_b() !== model(24, 1'b0, thresh)) begin
            errors++;
            $display("FAIL unsigned_top1 got=%h required=%h", obs_b(), model(24, 1'b0, thresh));
        end
        checks++;
        if (obs_a() !== model(24, 1'b1, thresh)) begin
            errors++;
            $display("FAIL unsigned_case_signed got=%h required=%h", obs_a(), model(24, 1'b1, thresh));
        end
        accept();
    endtask

    task automatic test_padding();
        for (int i = 0; i < 24; i++) fr[i] = 16'hFFFB;
        fr[10] = 16'h7FFF;
        fr[11] = 16'h7FFF;
        thresh = 16'd0;
        drive_beats(0, 3, 1'b1, 0);
        checks++;
        if (c_out_valid !== 1'b1 || c_i1 !== 4'd0 || c_i2 !== 4'd1 || obs_c() !== model(10, 1'b1, thresh)) begin
            errors++;
            $display("FAIL padding got=%b/%h required=1/%h", c_out_valid, obs_c(), model(10, 1'b1, thresh));
        end
        accept();
        rand_frame();
        thresh = 16'($urandom);
        drive_beats(0, 3, 1'b1, 30);
        checks++;
        if (obs_c() !== model(10, 1'b1, thresh)) begin
            errors++;
            $display("FAIL padding_rand got=%h required=%h", obs_c(), model(10, 1'b1, thresh));
        end
        accept();
    endtask

    task automatic test_backpressure();
        logic [58:0] exp_a;
        rand_frame();
        thresh = 16'($urandom_range(0, 2000));
        drive_beats(0, 6, 1'b0, 10);
        exp_a = model(24, 1'b1, thresh);
        for (int c = 0; c < 20; c++) begin
            in_valid = 1'b1;
            in_data = {$urandom, $urandom};
            thresh = 16'($urandom);
            checks++;
            if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || obs_a() !== exp_a) begin
                errors++;
                $display("FAIL stall_hold cyc=%0d got=%b/%b/%h required=0/1/%h",
                         c, a_in_ready, a_out_valid, obs_a(), exp_a);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        accept();
        checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || obs_a() !== exp_a) begin
            errors++;
            $display("FAIL release got=%b/%b/%h required=0/1/%h", a_out_valid, a_in_ready, obs_a(), exp_a);
        end
        rand_frame();
        drive_beats(0, 6, 1'b0, 10);
        checks++;
        if (obs_a() !== model(24, 1'b1, thresh)) begin
            errors++;
            $display("FAIL second_frame got=%h required=%h", obs_a(), model(24, 1'b1, thresh));
        end
        accept();
    endtask

    task automatic test_flush();
        logic [58:0] exp_a;
        for (int i = 0; i < 24; i++) fr[i] = 16'h7000;
        drive_beats(0, 3, 1'b0, 0);
        flush = 1'b1;
        in_valid = 1'b1;
        in_data = {4{16'h7FFF}};
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        rand_frame();
        thresh = 16'($urandom);
        drive_beats(0, 6, 1'b0, 0);
        exp_a = model(24, 1'b1, thresh);
        checks++;
        if (a_out_valid !== 1'b1 || obs_a() !== exp_a) begin
            errors++;
            $display("FAIL flush_midframe got=%b/%h required=1/%h", a_out_valid, obs_a(), exp_a);
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || obs_a() !== exp_a) begin
            errors++;
            $display("FAIL flush_done got=%b/%b/%h required=0/1/%h", a_out_valid, a_in_ready, obs_a(), exp_a);
        end
    endtask

    task automatic test_midframe_reset();
        rand_frame();
        drive_beats(0, 2, 1'b0, 0);
        #2 resetn = 1'b0;
        #1;
        checks++;
        if ({obs_a(), a_out_valid, a_in_ready} !== {59'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL async_reset got=%h/%b/%b required=0/0/1", obs_a(), a_out_valid, a_in_ready);
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        rand_frame();
        thresh = 16'($urandom_range(0, 300));
        drive_beats(0, 6, 1'b0, 0);
        checks++;
        if (a_out_valid !== 1'b1 || obs_a() !== model(24, 1'b1, thresh)) begin
            errors++;
            $display("FAIL after_reset got=%b/%h required=1/%h", a_out_valid, obs_a(), model(24, 1'b1, thresh));
        end
        accept();
    endtask

    task automatic test_back_to_back();
        int last_cyc = 0;
        out_ready = 1'b1;
        for (int f = 0; f < 30; f++) begin
            rand_frame();
            thresh = ($urandom_range(1) != 0) ? 16'($urandom) : 16'($urandom_range(0, 64));
            drive_beats(0, 6, 1'b0, (f < 10) ? 0 : 25);
            checks++;
            if (a_out_valid !== 1'b1 || obs_a() !== model(24, 1'b1, thresh)
                || obs_b() !== model(24, 1'b0, thresh)) begin
                errors++;
                $display("FAIL b2b frame=%0d got=%h/%h required=%h/%h", f, obs_a(), obs_b(),
                         model(24, 1'b1, thresh), model(24, 1'b0, thresh));
            end
            if (f > 0 && f < 10) begin
                checks++;
                if (cyc - last_cyc != 7) begin
                    errors++;
                    $display("FAIL throughput frame=%0d got=%0d required=7", f, cyc - last_cyc);
                end
            end
            last_cyc = cyc;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_ties();
        test_padding();
        test_backpressure();
        test_flush();
        test_midframe_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
